// File: rtl/axi_wr_resp_chnl_if.sv
// AXI write-response (B) channel bundle between the DDR4 slave and the AXI master.
// The slave modport drives the response; the master modport drives bready.
interface axi_wr_resp_chnl_if #(
  parameter int C_ID_WIDTH = 4
) ();
  logic [C_ID_WIDTH-1:0] s_axi_bid;
  logic [1:0]            s_axi_bresp;
  logic                  s_axi_bvalid;
  logic                  s_axi_bready;

  modport slave (
    output s_axi_bid,
    output s_axi_bresp,
    output s_axi_bvalid,
    input  s_axi_bready
  );

  modport master (
    input  s_axi_bid,
    input  s_axi_bresp,
    input  s_axi_bvalid,
    output s_axi_bready
  );
endinterface

// File: rtl/axi_wr_resp_chnl.sv
// Write-response generator: queues {AWID, err} per completed burst and returns
// them in order on the AXI B channel through a registered output stage.
module axi_wr_resp_chnl #(
  parameter int C_ID_WIDTH   = 4,
  parameter int C_FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  b_push,
  input  logic [C_ID_WIDTH-1:0] b_awid,
  input  logic                  b_err,
  output logic                  b_full,
  axi_wr_resp_chnl_if.slave     s_axi,
  output logic                  overflow
);

  localparam int ENTRIES = C_FIFO_DEPTH - 1;
  localparam int PTR_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CNT_W   = $clog2(C_FIFO_DEPTH) + 1;
  localparam int ENT_W   = C_ID_WIDTH + 1;

  typedef enum logic {ST_EMPTY, ST_VALID} state_t;

  state_t                state_reg;
  logic [C_ID_WIDTH-1:0] bid_reg;
  logic [1:0]            bresp_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [CNT_W-1:0]      count_next;
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic                  full_reg;
  logic                  overflow_reg;

  logic [ENT_W-1:0]      mem [ENTRIES];
  logic [ENT_W-1:0]      head;

  logic out_valid, pop, push_ok, fifo_empty, out_free;
  logic load_fifo, load_push, wr_fifo;
  logic [CNT_W-1:0] fifo_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ENTRIES - 1)) ? '0 : p + 1'b1;
  endfunction

  assign out_valid  = (state_reg == ST_VALID);
  assign pop        = out_valid && s_axi.s_axi_bready;
  assign push_ok    = b_push && !full_reg;
  assign fifo_count = count_reg - {{(CNT_W-1){1'b0}}, out_valid};
  assign fifo_empty = (fifo_count == '0);
  assign out_free   = !out_valid || pop;
  // The FIFO head always has priority over a new push, which keeps push order.
  assign load_fifo  = out_free && !fifo_empty;
  assign load_push  = out_free && fifo_empty && push_ok;
  assign wr_fifo    = push_ok && !load_push;
  assign head       = mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_fifo) mem[wr_ptr_reg] <= {b_awid, b_err};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_EMPTY;
      bid_reg      <= '0;
      bresp_reg    <= '0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      full_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      count_reg    <= count_next;
      full_reg     <= (count_next == CNT_W'(C_FIFO_DEPTH));
      overflow_reg <= overflow_reg | (b_push & full_reg);
      if (wr_fifo)   wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (load_fifo) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case (state_reg)
        ST_EMPTY: begin
          if (load_fifo) begin
            bid_reg   <= head[ENT_W-1:1];
            bresp_reg <= {head[0], 1'b0};
            state_reg <= ST_VALID;
          end else if (load_push) begin
            bid_reg   <= b_awid;
            bresp_reg <= {b_err, 1'b0};
            state_reg <= ST_VALID;
          end
        end
        ST_VALID: begin
          // Output fields only move on a handshake, so they stay stable while stalled.
          if (pop) begin
            if (load_fifo) begin
              bid_reg   <= head[ENT_W-1:1];
              bresp_reg <= {head[0], 1'b0};
            end else if (load_push) begin
              bid_reg   <= b_awid;
              bresp_reg <= {b_err, 1'b0};
            end else begin
              state_reg <= ST_EMPTY;
            end
          end
        end
        default: state_reg <= ST_EMPTY;
      endcase
    end
  end

  assign s_axi.s_axi_bid    = bid_reg;
  assign s_axi.s_axi_bresp  = bresp_reg;
  assign s_axi.s_axi_bvalid = out_valid;
  assign b_full             = full_reg;
  assign overflow           = overflow_reg;

endmodule

// File: tb/tb_axi_wr_resp_chnl.sv
// Bench for axi_wr_resp_chnl: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_axi_wr_resp_chnl;
  localparam int ID_W  = 4;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            b_push = 1'b0;
  logic [ID_W-1:0] b_awid = '0;
  logic            b_err = 1'b0;
  logic            b_full;
  logic            overflow;

  axi_wr_resp_chnl_if #(.C_ID_WIDTH(ID_W)) bif ();

  axi_wr_resp_chnl #(.C_ID_WIDTH(ID_W), .C_FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .b_push   (b_push),
    .b_awid   (b_awid),
    .b_err    (b_err),
    .b_full   (b_full),
    .s_axi    (bif),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: every accepted response waits in q, front is what the bus must show.
  logic [ID_W:0]   q[$];
  logic            m_ovf = 1'b0;
  bit              stall_prev = 1'b0;
  logic [ID_W-1:0] snap_bid;
  logic [1:0]      snap_resp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_ovf = 1'b0;
      stall_prev = 1'b0;
    end else begin
      bit m_pop, m_full;
      m_full = (q.size() == DEPTH);
      m_pop  = (q.size() > 0) && bif.s_axi_bready;
      stall_prev = bif.s_axi_bvalid && !bif.s_axi_bready;
      snap_bid   = bif.s_axi_bid;
      snap_resp  = bif.s_axi_bresp;
      if (m_pop) begin
        $display("B handshake: bid=%0d bresp=%0d", bif.s_axi_bid, bif.s_axi_bresp);
        void'(q.pop_front());
      end
      if (b_push) begin
        if (m_full) m_ovf = 1'b1;
        else        q.push_back({b_awid, b_err});
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("bvalid", bif.s_axi_bvalid, q.size() > 0);
      if (q.size() > 0) begin
        chk("bid", bif.s_axi_bid, q[0][ID_W:1]);
        chk("bresp", bif.s_axi_bresp, {q[0][0], 1'b0});
      end
      chk("b_full", b_full, q.size() == DEPTH);
      chk("overflow", overflow, m_ovf);
      if (stall_prev) begin
        chk("bid_stable", bif.s_axi_bid, snap_bid);
        chk("bresp_stable", bif.s_axi_bresp, snap_resp);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    bif.s_axi_bready = 1'b0;
    repeat (3) step();
    chk("rst_bvalid", bif.s_axi_bvalid, 0);
    chk("rst_bid", bif.s_axi_bid, 0);
    chk("rst_bresp", bif.s_axi_bresp, 0);
    chk("rst_b_full", b_full, 0);
    chk("rst_overflow", overflow, 0);
    reset_n = 1'b1;

    // Single response with bready already high.
    step(); b_push = 1; b_awid = 3; b_err = 0; bif.s_axi_bready = 1;
    step(); b_push = 0;
    chk("t1_bvalid", bif.s_axi_bvalid, 1);
    chk("t1_bid", bif.s_axi_bid, 3);
    chk("t1_bresp", bif.s_axi_bresp, 0);
    chk("t1_b_full", b_full, 0);
    step();
    chk("t1_bvalid_one_cycle", bif.s_axi_bvalid, 0);

    // Fill the store, then overflow push coinciding with the first pop.
    bif.s_axi_bready = 0;
    for (int i = 1; i <= 8; i++) begin
      step(); b_push = 1; b_awid = ID_W'(i); b_err = (i % 2 == 0);
    end
    step(); b_push = 0;
    chk("t2_full_after_8", b_full, 1);
    chk("t2_head_bid", bif.s_axi_bid, 1);
    bif.s_axi_bready = 1; b_push = 1; b_awid = 9; b_err = 0;
    step(); b_push = 0;
    chk("t3_overflow", overflow, 1);
    chk("t3_full_drops", b_full, 0);
    chk("t3_bid2", bif.s_axi_bid, 2);
    chk("t3_bresp2", bif.s_axi_bresp, 2'b10);
    for (int k = 3; k <= 8; k++) begin
      step();
      chk("t2_drain_bid", bif.s_axi_bid, k);
      chk("t2_drain_bresp", bif.s_axi_bresp, (k % 2 == 0) ? 2 : 0);
    end
    step();
    chk("t3_id9_never", bif.s_axi_bvalid, 0);

    // Push and pop together with an empty FIFO behind a valid output.
    bif.s_axi_bready = 0; b_push = 1; b_awid = 5; b_err = 1;
    step(); b_push = 1; b_awid = 6; b_err = 0; bif.s_axi_bready = 1;
    chk("t5_bid5", bif.s_axi_bid, 5);
    step(); b_push = 0;
    chk("t5_bvalid", bif.s_axi_bvalid, 1);
    chk("t5_bid6", bif.s_axi_bid, 6);
    chk("t5_bresp6", bif.s_axi_bresp, 0);
    step();
    chk("t5_empty", bif.s_axi_bvalid, 0);

    // Push every cycle with toggling bready, then fully random traffic.
    for (int i = 0; i < 40; i++) begin
      step(); b_push = 1; b_awid = ID_W'($urandom); b_err = 1'($urandom);
      bif.s_axi_bready = (i % 2 == 0);
    end
    for (int i = 0; i < 300; i++) begin
      step(); b_push = 1'($urandom_range(0, 1)); b_awid = ID_W'($urandom);
      b_err = 1'($urandom); bif.s_axi_bready = ($urandom_range(0, 3) != 0);
    end
    step(); b_push = 0; bif.s_axi_bready = 1;
    repeat (10) step();
    chk("t4_drained", bif.s_axi_bvalid, 0);

    // Asynchronous reset with five responses queued.
    bif.s_axi_bready = 0;
    for (int i = 0; i < 5; i++) begin
      step(); b_push = 1; b_awid = ID_W'(10 + i); b_err = 0;
    end
    step(); b_push = 0;
    step();
    #2 reset_n = 0;
    #1;
    chk("t6_bvalid_async", bif.s_axi_bvalid, 0);
    chk("t6_b_full_async", b_full, 0);
    chk("t6_overflow_async", overflow, 0);
    chk("t6_bid_async", bif.s_axi_bid, 0);
    step(); step();
    reset_n = 1;
    step(); b_push = 1; b_awid = 2; b_err = 0; bif.s_axi_bready = 1;
    step(); b_push = 0;
    chk("t6_bvalid", bif.s_axi_bvalid, 1);
    chk("t6_bid2", bif.s_axi_bid, 2);
    step();
    chk("t6_only_id2", bif.s_axi_bvalid, 0);
    step();
    chk("t6_still_empty", bif.s_axi_bvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_wr_resp_chnl.md
# axi_wr_resp_chnl

Write-response (B channel) generator for the DDR4 AXI slave. It takes the one-cycle `b_push` that the write command FSM issues when the last MC command of an AXI write burst is accepted, and queues the burst's AWID and error status. It then returns the response to the AXI master in order, and drives `b_full` back to the command FSM as flow control.

## Interface
- `C_ID_WIDTH`, 4: width of AWID/BID.
- `C_FIFO_DEPTH`, 8: total response capacity, including the output register; power of two, 2..32.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `b_push`  in  1  one-cycle pulse: the write burst's last MC command was accepted; enqueue one response.
- `b_awid`  in  C_ID_WIDTH  ID of the completed burst, sampled with `b_push`.
- `b_err`  in  1  burst failed (e.g. decode error), sampled with `b_push`; 1 -> SLVERR.
- `b_full`  out  1  registered; 1 when the response store is full; upstream must not push.
- `s_axi_bid`  out  C_ID_WIDTH  response ID.
- `s_axi_bresp`  out  2  `2'b00` OKAY or `2'b10` SLVERR.
- `s_axi_bvalid`  out  1  response valid.
- `s_axi_bready`  in  1  master accepts the response.
- `overflow`  out  1  sticky; set when `b_push` arrives while `b_full`=1; cleared only by reset.

## Operation
- Storage is a circular FIFO of C_FIFO_DEPTH-1 entries plus one output register that drives the `s_axi_b*` outputs. Each entry is {ID, err}.
- `count` (clog2(C_FIFO_DEPTH)+1 bits) tracks occupied entries across both FIFO and output register.
- Push accepted: `b_push`=1 and `b_full`=0.
  - Output register empty, or emptying this cycle with FIFO empty: the entry goes directly into the output register (fall-through).
  - Otherwise: the entry is written at `wr_ptr` and the pointer increments, wrapping modulo C_FIFO_DEPTH-1.
- Pop: `s_axi_bvalid`=1 and `s_axi_bready`=1. On the next edge the output register loads the FIFO head (`rd_ptr` increments, wraps), or takes the simultaneous push if the FIFO is empty, or else goes invalid.
- `count` changes as follows:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - rejected push: unchanged
- `b_full` <= (next `count` == C_FIFO_DEPTH).
- Push while `b_full`=1 is dropped even if a pop happens in the same cycle. It sets `overflow`. Store contents and `count` are unchanged.
- Responses are returned strictly in push order. IDs are not reordered.
- `s_axi_bresp` = {`err`, 1'b0}.
- State of the output stage is EMPTY (`bvalid`=0) or VALID (`bvalid`=1):
  - EMPTY -> VALID on an accepted push or when the FIFO is non-empty.
  - VALID -> EMPTY on pop when the FIFO is empty and there is no push.
  - VALID -> VALID on pop with a refill available, or while stalled.
- Once `s_axi_bvalid` is asserted, `s_axi_bid` and `s_axi_bresp` hold stable until the handshake completes (AXI rule). `bvalid` never depends combinationally on `bready`.

## Timing
- Reset (asynchronous assert, synchronous release by the system reset sync): `s_axi_bvalid`=0, `s_axi_bid`=0, `s_axi_bresp`=0, `b_full`=0, `overflow`=0, `count`=0, both pointers=0.
- Reset mid-operation discards all queued responses immediately.
- Latency: push at edge N into an empty block gives `s_axi_bvalid`=1 after edge N (visible cycle N+1).
- Throughput: one response per cycle when `bready` is held high.
- `b_full` asserts the cycle after the push that fills the store. It deasserts the cycle after the pop that frees an entry.
- Upstream samples `b_full` registered, so there is no combinational path from `s_axi_bready` to `b_full`.
- All outputs are registered.

## Test plan
- Reset, then push ID=3 with err=0 while `bready`=1 -> `bvalid` high for exactly one cycle with BID=3, BRESP=00; `b_full` stays 0.
- Hold `bready`=0 and push IDs 1..8 with err alternating 0/1 (C_FIFO_DEPTH=8) -> `b_full`=1 the cycle after the 8th push. Then raise `bready` -> responses 1..8 in order, BRESP 00/10 alternating, one per cycle; `b_full` drops after the first pop.
- With the store full, push ID=9 in the same cycle as a pop -> push dropped, `overflow`=1 and remains set, `count` becomes 7, ID 9 is never returned.
- Push every cycle while `bready` toggles 1/0 over 40 pushes -> pointer wraps, no loss or duplication, order preserved, BID/BRESP stable while `bvalid`=1 and `bready`=0.
- Push and pop in the same cycle with an empty FIFO and a valid output register -> the new entry appears the next cycle and `count` is unchanged.
- Deassert `reset_n` asynchronously with 5 responses queued -> `bvalid`=0, `b_full`=0 and `overflow`=0 immediately. After release, a push of ID=2 returns only ID=2.
